if_fetch_stage: RTL and testbench

// - Instruction-fetch stage upstream of decode in the RV32 core; owns the architectural fetch PC.
// - Issues word reads to instruction memory and buffers returned words with their PC in an in-order queue.
// - Presents pc/instr pairs to decode over a valid/ready handshake.
// - Handles redirects from execute; also provides the free-running cycle counter exported by top.

---
 rtl/if_fetch_stage.sv | 193 +++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: owns the fetch PC, issues credit-limited imem reads and queues
// returned words for decode. Define FETCH_PERF_EN to add perf_fetched/perf_stall counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] pc,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic [31:0] cycle
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   cycle_q;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [31:0]   pf_mem_q [QDEPTH];
    logic [PW-1:0] pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d;

    logic [31:0]   q_pc_q    [QDEPTH];
    logic [31:0]   q_instr_q [QDEPTH];
    logic [PW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [CW-1:0] q_cnt_q, q_cnt_d;

    logic [31:0]   hold_pc_q, hold_instr_q;

    logic credit_ok;
    logic req_fire;
    logic rsp_acc;
    logic rsp_keep;
    logic out_fire;

    // Every issued request must already own a queue slot, so responses can never overflow it.
    assign credit_ok      = ({1'b0, in_flight_q} + {1'b0, q_cnt_q}) < (CW + 1)'(QDEPTH);
    assign imem_req_valid = !reset && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_acc  = imem_rsp_valid && (in_flight_q != '0);
    assign rsp_keep = rsp_acc && (drop_q == '0) && !redirect_valid;

    assign out_valid = (q_cnt_q != '0);
    assign out_fire  = out_valid && out_ready;
    assign out_pc    = out_valid ? q_pc_q[q_rd_q]    : hold_pc_q;
    assign out_instr = out_valid ? q_instr_q[q_rd_q] : hold_instr_q;

    assign pc    = pc_q;
    assign cycle = cycle_q;

    always_comb begin
        pc_d        = pc_q;
        in_flight_d = in_flight_q;
        drop_d      = drop_q;
        pf_wr_d     = pf_wr_q;
        pf_rd_d     = pf_rd_q;
        q_wr_d      = q_wr_q;
        q_rd_d      = q_rd_q;
        q_cnt_d     = q_cnt_q;

        if (req_fire && !rsp_acc) begin
            in_flight_d = in_flight_q + CW'(1);
        end else if (!req_fire && rsp_acc) begin
            in_flight_d = in_flight_q - CW'(1);
        end

        // A redirect squashes everything outstanding, including a request issued this same cycle.
        if (redirect_valid) begin
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            drop_d  = in_flight_d;
            pf_wr_d = '0;
            pf_rd_d = '0;
            q_wr_d  = '0;
            q_rd_d  = '0;
            q_cnt_d = '0;
        end else begin
            if (req_fire) begin
                pc_d    = pc_q + 32'd4;
                pf_wr_d = pf_wr_q + PW'(1);
            end
            if (rsp_acc && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_keep) begin
                pf_rd_d = pf_rd_q + PW'(1);
                q_wr_d  = q_wr_q + PW'(1);
            end
            if (out_fire) begin
                q_rd_d = q_rd_q + PW'(1);
            end
            if (rsp_keep && !out_fire) begin
                q_cnt_d = q_cnt_q + CW'(1);
            end else if (!rsp_keep && out_fire) begin
                q_cnt_d = q_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            cycle_q      <= '0;
            in_flight_q  <= '0;
            drop_q       <= '0;
            pf_wr_q      <= '0;
            pf_rd_q      <= '0;
            q_wr_q       <= '0;
            q_rd_q       <= '0;
            q_cnt_q      <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else begin
            pc_q        <= pc_d;
            cycle_q     <= cycle_q + 32'd1;
            in_flight_q <= in_flight_d;
            drop_q      <= drop_d;
            pf_wr_q     <= pf_wr_d;
            pf_rd_q     <= pf_rd_d;
            q_wr_q      <= q_wr_d;
            q_rd_q      <= q_rd_d;
            q_cnt_q     <= q_cnt_d;
            if (out_valid) begin
                hold_pc_q    <= q_pc_q[q_rd_q];
                hold_instr_q <= q_instr_q[q_rd_q];
            end
        end
    end

    // Storage arrays: PC-FIFO tracks addresses of live requests, queue pairs them with returned words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                pf_mem_q[i]  <= '0;
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else begin
            if (req_fire && !redirect_valid) begin
                pf_mem_q[pf_wr_q] <= pc_q;
            end
            if (rsp_keep) begin
                q_pc_q[q_wr_q]    <= pf_mem_q[pf_rd_q];
                q_instr_q[q_wr_q] <= imem_rsp_data;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (out_fire) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (!out_valid) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

    a_rsp_unexpected: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && (in_flight_q == '0)));

    a_queue_overflow: assert property (@(posedge clk) disable iff (reset)
        !(rsp_keep && (q_cnt_q == CW'(QDEPTH))));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised bench for if_fetch_stage: a queue-based reference model plus an in-order memory
// model with configurable latency, followed by directed throughput, backpressure and redirect steps.
module tb_if_fetch_stage;

    localparam int          QD     = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] pc;
    logic [31:0] cycle;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .pc(pc), .cycle(cycle)
    );

    int nVec = 0;
    int nErr = 0;

    // Reference model: architectural fetch state held as plain counters and queues.
    logic [31:0] mPc, mCycle;
    int          mInflight, mDrop;
    logic [31:0] mPcFifo[$];
    logic [31:0] mQPc[$];
    logic [31:0] mQInstr[$];

    // Memory model: accepted addresses with the step at which each response becomes due.
    logic [31:0] memAddr[$];
    int          memDue[$];
    int          tNow = 0;

    int          rdyProb, ordyProb, redirProb, latMin, latMax;
    bit          rdyToggle, redirForce;
    logic [31:0] redirTarget;
    int          accCnt;
    bit          lastFire, lastValid;
    logic [31:0] lastFirePc;
    logic [31:0] expPc;
    int          nFire;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        if (memAddr.size() != 0 && tNow >= memDue[0]) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(memAddr[0]);
            void'(memAddr.pop_front());
            void'(memDue.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        if (rdyToggle) imem_req_ready = (tNow % 2 == 0);
        else           imem_req_ready = ($urandom_range(99) < rdyProb);
        out_ready = ($urandom_range(99) < ordyProb);
        if (redirForce) begin
            redirect_valid = 1'b1;
            redirect_pc    = redirTarget;
        end else begin
            redirect_valid = ($urandom_range(99) < redirProb);
            redirect_pc    = $urandom;
        end
    endtask

    task automatic checkOutput();
        logic expReq;
        expReq = (mInflight + mQPc.size() < QD);
        chk("req_valid", imem_req_valid, expReq);
        chk("req_addr", imem_req_addr, mPc);
        chk("pc", pc, mPc);
        chk("cycle", cycle, mCycle);
        chk("out_valid", out_valid, mQPc.size() != 0);
        if (mQPc.size() != 0) begin
            chk("out_pc", out_pc, mQPc[0]);
            chk("out_instr", out_instr, mQInstr[0]);
        end
    endtask

    task automatic modelStep();
        bit fire, rspAcc, oFire;
        fire   = (mInflight + mQPc.size() < QD) && imem_req_ready;
        rspAcc = imem_rsp_valid && (mInflight > 0);
        oFire  = (mQPc.size() != 0) && out_ready;
        mCycle = mCycle + 32'd1;
        mInflight = mInflight + int'(fire) - int'(rspAcc);
        if (redirect_valid) begin
            mPc = redirect_pc & ~32'h3;
            mPcFifo.delete();
            mQPc.delete();
            mQInstr.delete();
            mDrop = mInflight;
        end else begin
            if (oFire) begin
                void'(mQPc.pop_front());
                void'(mQInstr.pop_front());
            end
            if (rspAcc) begin
                if (mDrop > 0) begin
                    mDrop--;
                end else begin
                    mQPc.push_back(mPcFifo.size() != 0 ? mPcFifo.pop_front() : 32'hDEAD_DEAD);
                    mQInstr.push_back(imem_rsp_data);
                end
            end
            if (fire) begin
                mPcFifo.push_back(mPc);
                mPc = mPc + 32'd4;
            end
        end
    endtask

    // One clock: drive at the falling edge, check 1 time unit later, advance models.
    task automatic step();
        applyStimulus();
        #1;
        checkOutput();
        lastValid  = out_valid;
        lastFire   = out_valid && out_ready;
        lastFirePc = out_pc;
        if (imem_req_valid && imem_req_ready) begin
            accCnt++;
            memAddr.push_back(imem_req_addr);
            memDue.push_back(tNow + int'($urandom_range(latMax, latMin)));
        end
        modelStep();
        tNow++;
        @(negedge clk);
    endtask

    task automatic doReset();
        #2 reset = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_cycle", cycle, 32'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        mPc = RST_PC; mCycle = '0; mInflight = 0; mDrop = 0;
        mPcFifo.delete(); mQPc.delete(); mQInstr.delete();
        memAddr.delete(); memDue.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        rdyToggle = 1'b0; redirForce = 1'b0; redirTarget = '0; redirProb = 0;
        accCnt = 0;
        @(negedge clk);
        doReset();

        // Single-cycle memory with decode always ready: one instruction per cycle after two cycles.
        latMin = 1; latMax = 1; rdyProb = 100; ordyProb = 100;
        expPc = RST_PC; nFire = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("a_valid_timing", lastValid, i >= 2);
            if (lastFire) begin
                chk("a_seq_pc", lastFirePc, expPc);
                expPc = expPc + 32'd4;
                nFire++;
            end
        end
        chk("a_fire_count", nFire, 14);

        // Decode stalled: only QDEPTH requests may be accepted, then everything drains in order.
        doReset();
        ordyProb = 0; accCnt = 0;
        repeat (10) step();
        chk("b_accepted", accCnt, QD);
        chk("b_req_stalled", imem_req_valid, 1'b0);
        ordyProb = 100; expPc = RST_PC; nFire = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (lastFire) begin
                chk("b_order_pc", lastFirePc, expPc);
                expPc = expPc + 32'd4;
                nFire++;
            end
        end
        chk("b_drained", nFire >= QD, 1'b1);

        // Redirect to 0x103 with two requests outstanding; both stale words must vanish.
        doReset();
        latMin = 3; latMax = 3; rdyProb = 100; ordyProb = 100;
        for (int i = 0; i < 40 && mInflight != 2; i++) step();
        chk("c_inflight_reached", mInflight, 2);
        redirForce = 1'b1; redirTarget = 32'h0000_0103; rdyProb = 0;
        step();
        redirForce = 1'b0; rdyProb = 100;
        for (int i = 0; i < 40 && !out_valid; i++) step();
        chk("c_out_valid", out_valid, 1'b1);
        chk("c_first_pc", out_pc, 32'h0000_0100);
        expPc = 32'h0000_0100;
        for (int i = 0; i < 8; i++) begin
            step();
            if (lastFire) begin
                chk("c_seq_pc", lastFirePc, expPc);
                expPc = expPc + 32'd4;
            end
        end

        // Latency 3 with request-ready toggling every cycle and intermittent decode stalls.
        rdyToggle = 1'b1; ordyProb = 70; nFire = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (lastFire) nFire++;
        end
        chk("d_progress", nFire > 0, 1'b1);
        rdyToggle = 1'b0;

        // Fully random traffic including redirects to arbitrary (misaligned) targets.
        latMin = 1; latMax = 4; rdyProb = 60; ordyProb = 60; redirProb = 4;
        repeat (400) step();

        // Reset in the middle of live traffic, then confirm a clean restart.
        doReset();
        redirProb = 2;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

endmodule
